// File: rtl/interleave_frame_packer_if.sv
// Byte-stream input and packed-frame output bundle of interleave_frame_packer.
// The master modport is the packer's own view; slave is the surrounding environment.
interface interleave_frame_packer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       in_last;
    logic [7:0] out_byte0;
    logic [7:0] out_byte1;
    logic [7:0] out_byte2;
    logic [7:0] out_byte3;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_pad;

    modport master (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_byte0, out_byte1, out_byte2, out_byte3, out_valid, out_pad
    );

    modport slave (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_byte0, out_byte1, out_byte2, out_byte3, out_valid, out_pad
    );
endinterface

// File: rtl/interleave_frame_packer.sv
// Packs 4 consecutive stream bytes into one parallel frame for the 2-bit-group interleaver.
// Optional macro PAD_FLUSH_EN: in_last closes a partial frame with zero padding.
module interleave_frame_packer #(
    parameter bit LSB_FIRST   = 1'b1,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    interleave_frame_packer_if.master bus,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    typedef enum logic [1:0] {
        FILL = 2'b00,
        HOLD = 2'b01
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      idx;
    logic [1:0]      idx_next;
    logic [3:0][7:0] asm_q;
    logic [3:0][7:0] asm_d;
    logic [3:0][7:0] frame;
    logic [3:0][7:0] load_frame;
    logic [3:0][7:0] out_q;
    logic            out_valid_q;
    logic            out_valid_d;
    logic            load_out;
    logic            accept;
    logic            deliver;
    logic            last_in;
    logic            complete;

    // Arrival slot -> output byte position, so the assembly register is kept in output order.
    function automatic logic [1:0] slot_pos(input logic [1:0] s);
        return LSB_FIRST ? s : 2'd3 - s;
    endfunction

`ifdef PAD_FLUSH_EN
    logic [1:0] frame_pad;
    logic [1:0] hold_pad_q;
    logic [1:0] hold_pad_d;
    logic [1:0] load_pad;
    logic [1:0] out_pad_q;

    assign last_in   = bus.in_last;
    assign frame_pad = 2'd3 - idx;
`else
    logic unused_in_last;

    assign last_in        = 1'b0;
    assign unused_in_last = bus.in_last;
`endif

    assign bus.in_ready  = (state == FILL);
    assign accept        = bus.in_valid && (state == FILL);
    assign deliver       = out_valid_q && bus.out_ready;
    assign complete      = accept && ((idx == 2'd3) || last_in);

    // Completed frame: stored slots, the byte arriving now, zeros for any slots never filled.
    always_comb begin
        frame = '0;
        for (int s = 0; s < 4; s++) begin
            if (2'(s) < idx)
                frame[slot_pos(2'(s))] = asm_q[slot_pos(2'(s))];
            else if (2'(s) == idx)
                frame[slot_pos(2'(s))] = bus.in_data;
            else
                frame[slot_pos(2'(s))] = 8'h00;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        asm_d      = asm_q;
        load_out   = 1'b0;
        load_frame = frame;
`ifdef PAD_FLUSH_EN
        hold_pad_d = hold_pad_q;
        load_pad   = frame_pad;
`endif
        case (state)
            FILL: begin
                if (complete) begin
                    idx_next = 2'd0;
                    asm_d    = frame;
`ifdef PAD_FLUSH_EN
                    hold_pad_d = frame_pad;
`endif
                    if (!out_valid_q || bus.out_ready)
                        load_out = 1'b1;
                    else
                        state_next = HOLD;
                end else if (accept) begin
                    asm_d[slot_pos(idx)] = bus.in_data;
                    idx_next             = idx + 2'd1;
                end
            end
            HOLD: begin
                if (!out_valid_q || bus.out_ready) begin
                    load_out   = 1'b1;
                    load_frame = asm_q;
`ifdef PAD_FLUSH_EN
                    load_pad   = hold_pad_q;
`endif
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
                idx_next   = 2'd0;
            end
        endcase
    end

    // A load on the same edge as a delivery keeps out_valid high for back-to-back frames.
    always_comb begin
        out_valid_d = out_valid_q;
        if (load_out)
            out_valid_d = 1'b1;
        else if (deliver)
            out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            idx         <= 2'd0;
            asm_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            asm_q       <= asm_d;
            out_valid_q <= out_valid_d;
            if (load_out)
                out_q <= load_frame;
            if (deliver)
                frame_count <= frame_count + FRAME_CNT_W'(1);
        end
    end

`ifdef PAD_FLUSH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_pad_q <= 2'd0;
            out_pad_q  <= 2'd0;
        end else begin
            hold_pad_q <= hold_pad_d;
            if (load_out)
                out_pad_q <= load_pad;
        end
    end

    assign bus.out_pad = out_pad_q;
`else
    assign bus.out_pad = 2'b00;
`endif

    assign bus.out_byte0 = out_q[0];
    assign bus.out_byte1 = out_q[1];
    assign bus.out_byte2 = out_q[2];
    assign bus.out_byte3 = out_q[3];
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_interleave_frame_packer.sv
// Self-checking bench for interleave_frame_packer: LSB_FIRST=1 and LSB_FIRST=0 instances
// share one stimulus stream and one reference scoreboard.
module tb_interleave_frame_packer;

`ifdef PAD_FLUSH_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] fc_l;
    logic [15:0] fc_m;

    interleave_frame_packer_if bus_l ();
    interleave_frame_packer_if bus_m ();

    interleave_frame_packer #(.LSB_FIRST(1'b1), .FRAME_CNT_W(16)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .bus(bus_l), .frame_count(fc_l)
    );

    interleave_frame_packer #(.LSB_FIRST(1'b0), .FRAME_CNT_W(16)) dut_msb (
        .clk(clk), .rst_n(rst_n), .bus(bus_m), .frame_count(fc_m)
    );

    assign bus_m.in_data   = bus_l.in_data;
    assign bus_m.in_valid  = bus_l.in_valid;
    assign bus_m.in_last   = bus_l.in_last;
    assign bus_m.out_ready = bus_l.out_ready;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][7:0] b;
        logic [1:0]      pad;
    } frame_t;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ordy;
        logic       exp_ov;
        logic       exp_ir;
    } vec_t;

    frame_t      sb[$];
    logic [7:0]  mbytes[4];
    int          midx;
    logic [15:0] model_count;
    int          delivered;
    int          compared;
    int          mismatched;
    vec_t        vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compares the frame being delivered this cycle against the oldest expected frame.
    task automatic checkOutput();
        frame_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_frame: got %0h%0h%0h%0h expected none",
                     bus_l.out_byte3, bus_l.out_byte2, bus_l.out_byte1, bus_l.out_byte0);
            return;
        end
        e = sb.pop_front();
        check("count_lsb", 32'(fc_l), 32'(model_count));
        check("count_msb", 32'(fc_m), 32'(model_count));
        check("msb_valid", 32'(bus_m.out_valid), 32'd1);
        check("bytes_lsb", {bus_l.out_byte3, bus_l.out_byte2, bus_l.out_byte1, bus_l.out_byte0}, e.b);
        check("bytes_msb", {bus_m.out_byte3, bus_m.out_byte2, bus_m.out_byte1, bus_m.out_byte0},
              {e.b[0], e.b[1], e.b[2], e.b[3]});
        check("pad_lsb", 32'(bus_l.out_pad), 32'(e.pad));
        check("pad_msb", 32'(bus_m.out_pad), 32'(e.pad));
        model_count = model_count + 16'd1;
        delivered++;
    endtask

    // Drives one cycle of inputs after the falling edge and updates the reference model.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic ordy);
        frame_t f;
        logic   acc;
        @(negedge clk);
        bus_l.in_valid  = v;
        bus_l.in_data   = d;
        bus_l.in_last   = l;
        bus_l.out_ready = ordy;
        #1;
        acc = v && bus_l.in_ready;
        if (bus_l.out_valid && ordy)
            checkOutput();
        if (acc) begin
            mbytes[midx] = d;
            if (midx == 3 || (PAD_EN && l)) begin
                f.b = '0;
                for (int k = 0; k <= midx; k++)
                    f.b[k] = mbytes[k];
                f.pad = 2'(3 - midx);
                sb.push_back(f);
                midx = 0;
            end else begin
                midx++;
            end
        end
    endtask

    initial begin
        int cycles;
        int target;

        compared    = 0;
        mismatched  = 0;
        delivered   = 0;
        midx        = 0;
        model_count = 16'd0;

        vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 8'h08, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

        rst_n           = 1'b0;
        bus_l.in_valid  = 1'b0;
        bus_l.in_data   = 8'h00;
        bus_l.in_last   = 1'b0;
        bus_l.out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus_l.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus_l.in_ready), 32'd1);
        check("rst_count", 32'(fc_l), 32'd0);
        check("rst_bytes", {bus_l.out_byte3, bus_l.out_byte2, bus_l.out_byte1, bus_l.out_byte0}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed table: single frame, then held back-to-back frames");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].v, vecs[i].d, 1'b0, vecs[i].ordy);
            check($sformatf("vec%0d_out_valid", i), 32'(bus_l.out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d_in_ready", i), 32'(bus_l.in_ready), 32'(vecs[i].exp_ir));
        end
        check("table_count", 32'(fc_l), 32'd3);

        $display("[TB] in_last flush sequence");
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hBB, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
            check($sformatf("flush_out_valid%0d", i), 32'(bus_l.out_valid), 32'((i == 0) && PAD_EN));
        end
`ifdef PAD_FLUSH_EN
        applyStimulus(1'b1, 8'hC1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hC2, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hC3, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'hC4, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hC5, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hC6, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hC7, 1'b1, 1'b1);
`else
        applyStimulus(1'b1, 8'hCC, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hDD, 1'b0, 1'b1);
`endif
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        $display("[TB] randomised handshakes, 1000 frames");
        target = delivered + 1000;
        cycles = 0;
        while (delivered < target && cycles < 30000) begin
            applyStimulus($urandom_range(0, 99) < 70, 8'($urandom), 1'b0, $urandom_range(0, 99) < 60);
            cycles++;
        end
        check("random_frames_done", 32'(delivered >= target), 32'd1);
        repeat (6) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check("random_count", 32'(fc_l), 32'(model_count));

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        bus_l.in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus_l.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus_l.in_ready), 32'd1);
        check("midrst_count", 32'(fc_l), 32'd0);
        check("midrst_count_msb", 32'(fc_m), 32'd0);
        sb.delete();
        midx        = 0;
        model_count = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hE2, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hE3, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hE4, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check("post_rst_count", 32'(fc_l), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
